systolic_sequencer: RTL and testbench



---
 rtl/systolic_sequencer.sv | 157 +++++++++++++++
 tb/tb_systolic_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Control FSM sequencing one 4x4 systolic matrix-multiply job: load, clear, feed, drain, done.
// Define SYSTOLIC_SEQ_PERF_EN to add the jobs_done / busy_cycles performance counters.
module systolic_sequencer #(
    parameter int FEED_LEN     = 7,
    parameter int DRAIN_CYCLES = 7,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             load,
    output logic [CNT_W-1:0] count,
    output logic             pe_clear,
    output logic             pe_en,
    output logic             busy,
    output logic             done
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [15:0]      jobs_done,
    output logic [31:0]      busy_cycles
`endif
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(FEED_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DW-1:0]    DRN_LAST  = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]    DRN_ONE   = DW'(1);

    typedef enum logic [2:0] {
        IDLE, LOAD, CLEAR, FEED, DRAIN, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pe_clear_q, pe_clear_d;
    logic             pe_en_q, pe_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [15:0]      jobs_done_q, jobs_done_d;
    logic [31:0]      busy_cycles_q, busy_cycles_d;
`endif

    // Outputs are computed for the next state so they are live in that state's own cycle.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        load_d     = 1'b0;
        count_d    = '0;
        pe_clear_d = 1'b0;
        pe_en_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d    = CLEAR;
                pe_clear_d = 1'b1;
                busy_d     = 1'b1;
            end
            CLEAR: begin
                state_d = FEED;
                count_d = CNT_ONE;
                busy_d  = 1'b1;
            end
            FEED: begin
                busy_d  = 1'b1;
                pe_en_d = 1'b1;
                if (count_q == FEED_LAST) begin
                    state_d = DRAIN;
                    drain_d = DRN_ONE;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (drain_q == DRN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DRN_ONE;
                    pe_en_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            load_d     = 1'b0;
            count_d    = '0;
            pe_clear_d = 1'b0;
            pe_en_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
`ifdef SYSTOLIC_SEQ_PERF_EN
        jobs_done_d   = jobs_done_q;
        if (done_d && jobs_done_q != 16'hFFFF)
            jobs_done_d = jobs_done_q + 16'd1;
        busy_cycles_d = busy_cycles_q + {31'd0, busy_q};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            drain_q    <= '0;
            load_q     <= 1'b0;
            count_q    <= '0;
            pe_clear_q <= 1'b0;
            pe_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SYSTOLIC_SEQ_PERF_EN
            jobs_done_q   <= '0;
            busy_cycles_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            load_q     <= load_d;
            count_q    <= count_d;
            pe_clear_q <= pe_clear_d;
            pe_en_q    <= pe_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SYSTOLIC_SEQ_PERF_EN
            jobs_done_q   <= jobs_done_d;
            busy_cycles_q <= busy_cycles_d;
`endif
        end
    end

    assign load     = load_q;
    assign count    = count_q;
    assign pe_clear = pe_clear_q;
    assign pe_en    = pe_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef SYSTOLIC_SEQ_PERF_EN
    assign jobs_done   = jobs_done_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed self-checking bench for systolic_sequencer.
// Outputs are packed as {load,count,pe_clear,pe_en,busy,done} and checked per cycle.
module tb_systolic_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       load;
    logic [5:0] count;
    logic       pe_clear;
    logic       pe_en;
    logic       busy;
    logic       done;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [15:0] jobs_done;
    logic [31:0] busy_cycles;
`endif

    int checks = 0;
    int errors = 0;

    systolic_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .load     (load),
        .count    (count),
        .pe_clear (pe_clear),
        .pe_en    (pe_en),
        .busy     (busy),
        .done     (done)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .jobs_done   (jobs_done),
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {load, count, pe_clear, pe_en, busy, done};

    // Expected outputs in cycle t of a job whose LOAD cycle is t=1.
    function automatic logic [10:0] exp_vec(int t);
        logic       l, pc, pe, b, d;
        logic [5:0] c;
        l  = (t == 1);
        pc = (t == 2);
        c  = (t >= 3 && t <= 9) ? 6'(t - 2) : 6'd0;
        pe = (t >= 4 && t <= 16);
        b  = (t >= 1 && t <= 17);
        d  = (t == 17);
        return {l, c, pc, pe, b, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        step(); step();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", obs, 11'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== 11'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d] got %h want %h", i, obs, 11'd0);
            end
        end
    endtask

    task automatic test_single_job();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 19; t++) begin
            checks++;
            if (obs !== exp_vec(t)) begin
                errors++;
                $display("FAIL single_job T%0d got %h want %h", t, obs, exp_vec(t));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        // One job plus one idle cycle gives an 18-cycle period.
        for (int t = 1; t <= 40; t++) begin
            checks++;
            if (obs !== exp_vec(((t - 1) % 18) + 1)) begin
                errors++;
                $display("FAIL back_to_back T%0d got %h want %h",
                         t, obs, exp_vec(((t - 1) % 18) + 1));
            end
            step();
        end
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL b2b_abort got %h want %h", obs, 11'd0);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 22; t++) begin
            if (done) dones++;
            checks++;
            if (obs !== exp_vec(t)) begin
                errors++;
                $display("FAIL start_ignored T%0d got %h want %h", t, obs, exp_vec(t));
            end
            start = (t == 5 || t == 12);
            step();
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL start_ignored_dones got %0d want 1", dones);
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            checks++;
            if (obs !== exp_vec(t)) begin
                errors++;
                $display("FAIL abort_pre T%0d got %h want %h", t, obs, exp_vec(t));
            end
            if (t < 6) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL abort_T7 got %h want %h", obs, 11'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            checks++;
            if (obs !== exp_vec(t)) begin
                errors++;
                $display("FAIL abort_restart T%0d got %h want %h", t, obs, exp_vec(t));
            end
            step();
        end
    endtask

    task automatic test_abort_done_and_idle();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        checks++;
        if (obs !== exp_vec(17)) begin
            errors++;
            $display("FAIL abort_done_pulse got %h want %h", obs, exp_vec(17));
        end
        abort = 1'b1;
        step();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL abort_after_done got %h want %h", obs, 11'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (obs !== exp_vec(1)) begin
            errors++;
            $display("FAIL start_beats_abort got %h want %h", obs, exp_vec(1));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL abort_in_load got %h want %h", obs, 11'd0);
        end
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        checks++;
        if (obs !== exp_vec(10)) begin
            errors++;
            $display("FAIL rst_mid_T10 got %h want %h", obs, exp_vec(10));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_T11 got %h want %h", obs, 11'd0);
        end
        step();
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_T12 got %h want %h", obs, 11'd0);
        end
    endtask

`ifdef SYSTOLIC_SEQ_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (18) step();
        end
        checks++;
        if (jobs_done !== 16'd3) begin
            errors++;
            $display("FAIL perf_jobs got %0d want 3", jobs_done);
        end
        checks++;
        if (busy_cycles !== 32'd51) begin
            errors++;
            $display("FAIL perf_busy got %0d want 51", busy_cycles);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (jobs_done !== 16'd3 || busy_cycles !== 32'd52) begin
            errors++;
            $display("FAIL perf_abort got %0d/%0d want 3/52", jobs_done, busy_cycles);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (jobs_done !== 16'd0 || busy_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst got %0d/%0d want 0/0", jobs_done, busy_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_abort_done_and_idle();
        test_reset_mid_job();
`ifdef SYSTOLIC_SEQ_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
